riscv_mem_arbiter: RTL and testbench

- Shares the single-port synchronous RAM (ramm) between the CPU instruction-fetch path and the load/store path.
- Sequences each access onto the RAM, including read-modify-write for byte and halfword stores, since the RAM has no byte enables.
- Returns raw 32-bit words to requesters; load sign/zero extension remains in the CPU.
- Sits between riscv_cpu and ramm.

---
 rtl/riscv_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port synchronous RAM between the CPU
// fetch path and the load/store path. Byte and halfword stores become
// read-modify-write sequences because the RAM has no byte enables.
module riscv_mem_arbiter #(
  parameter int ADDR_W          = 8,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_wren,
  input  logic [31:0]       ram_q
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [2:0] {
    IDLE, RD, RESP, WR, RMW_RD, RMW_MRG, RMW_WR, ACK
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                lat_fetch;
  logic [1:0]          lat_size;
  logic [1:0]          lat_lane;
  logic [15:0]         lat_wdata;

  logic                grant_data;
  logic                grant_fetch;
  logic                d_misaligned;
  logic [31:0]         merged;

  // Address bits below the word or above the RAM size are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2]};

  // Read data is handed back raw; extension of loads happens in the CPU.
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;
  assign ram_wren = (state == WR) || (state == RMW_WR);

  // Alignment check and arbitration: data wins unless fetch has waited out a full streak.
  always_comb begin
    d_misaligned = (d_size == 2'b11)
                || ((d_size == 2'b01) && d_addr[0])
                || ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
    grant_data   = d_req && (!i_req || (streak != STREAK_W'(MAX_DATA_STREAK)));
    grant_fetch  = i_req && !grant_data;
  end

  // Replace the addressed little-endian lane(s) of the old word with the store data.
  always_comb begin
    merged = ram_q;
    if (lat_size == 2'b00)
      merged[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
  end

  // Access sequencer: accepts one request in IDLE and walks it through the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      lat_fetch <= 1'b0;
      lat_size  <= 2'b00;
      lat_lane  <= 2'b00;
      lat_wdata <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            lat_fetch <= 1'b0;
            lat_size  <= d_size;
            lat_lane  <= d_addr[1:0];
            lat_wdata <= d_wdata[15:0];
            ram_addr  <= d_addr[ADDR_W+1:2];
            streak    <= i_req ? streak + 1'b1 : '0;
            if (d_misaligned) begin
              state <= ACK;
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else if (!d_we) begin
              state <= RD;
            end else if (d_size == 2'b10) begin
              state    <= WR;
              ram_data <= d_wdata;
            end else begin
              state <= RMW_RD;
            end
          end else if (grant_fetch) begin
            lat_fetch <= 1'b1;
            ram_addr  <= i_addr[ADDR_W+1:2];
            streak    <= '0;
            state     <= RD;
          end
        end
        RD: begin
          state <= RESP;
          if (lat_fetch) i_ack <= 1'b1;
          else           d_ack <= 1'b1;
        end
        RESP:    state <= IDLE;
        WR: begin
          state <= ACK;
          d_ack <= 1'b1;
        end
        RMW_RD:  state <= RMW_MRG;
        RMW_MRG: begin
          ram_data <= merged;
          state    <= RMW_WR;
        end
        RMW_WR: begin
          state <= ACK;
          d_ack <= 1'b1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed vector table plus hand-written sequences for
// arbitration fairness and reset in the middle of a read-modify-write.
module tb_riscv_mem_arbiter;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data;
  logic              ram_wren;
  logic [31:0]       ram_q;

  logic [31:0]       mem [0:255];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  int checks;
  int passes;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_wr;
    int          word_idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [14];

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with a side port for preloading words.
  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request from an idle arbiter and watch it until its ack.
  task automatic applyStimulus(input vec_t v, output int lat, output logic got_err,
                               output logic [31:0] got_rdata, output int wr_cnt,
                               output logic [ADDR_W-1:0] wr_addr, output logic both,
                               output logic wrong_port, output logic timeout);
    logic done;
    lat = 0; wr_cnt = 0; wr_addr = '0; both = 1'b0; wrong_port = 1'b0;
    got_err = 1'b0; got_rdata = '0; done = 1'b0;
    @(negedge clk);
    if (v.fetch) begin
      i_req  = 1'b1;
      i_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_size  = v.size;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ram_wren) begin
        wr_cnt++;
        wr_addr = ram_addr;
      end
      if (i_ack && d_ack) both = 1'b1;
      if (v.fetch ? d_ack : i_ack) wrong_port = 1'b1;
      if (v.fetch ? i_ack : d_ack) begin
        done      = 1'b1;
        got_err   = d_err;
        got_rdata = v.fetch ? i_rdata : d_rdata;
      end
    end
    timeout = !done;
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (ram_wren) wr_cnt++;
  endtask

  task automatic runVector(input int i, input vec_t v);
    int                lat;
    int                wr_cnt;
    logic              got_err;
    logic [31:0]       got_rdata;
    logic [ADDR_W-1:0] wr_addr;
    logic              both;
    logic              wrong_port;
    logic              timeout;
    applyStimulus(v, lat, got_err, got_rdata, wr_cnt, wr_addr, both, wrong_port, timeout);
    checkOutput($sformatf("v%0d_timeout", i), {31'b0, timeout}, 32'h0);
    checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_err", i), {31'b0, got_err}, {31'b0, v.exp_err});
    checkOutput($sformatf("v%0d_wren_cycles", i), 32'(wr_cnt), 32'(v.exp_wr));
    checkOutput($sformatf("v%0d_both_acks", i), {31'b0, both}, 32'h0);
    checkOutput($sformatf("v%0d_wrong_port_ack", i), {31'b0, wrong_port}, 32'h0);
    if (v.chk_rdata)
      checkOutput($sformatf("v%0d_rdata", i), got_rdata, v.exp_rdata);
    if (v.exp_wr > 0)
      checkOutput($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(v.word_idx));
    checkOutput($sformatf("v%0d_mem_word", i), mem[v.word_idx], v.exp_word);
  endtask

  // Main test sequence.
  initial begin
    logic [9:0] seq;
    int         k;
    int         ncyc;
    logic       both;
    vec_t       fv;

    checks = 0; passes = 0;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    //                 fetch we    size   addr      wdata         lat err   chk   rdata          wr idx word
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h14,  32'h0,        2, 1'b0, 1'b1, 32'h00500093, 0, 5,  32'h00500093};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 32'h20,  32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0,        1, 8,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 2'b10, 32'h20,  32'h0,        2, 1'b0, 1'b1, 32'hDEADBEEF, 0, 8,  32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 32'h22,  32'h0000005A, 4, 1'b0, 1'b0, 32'h0,        1, 8,  32'hDE5ABEEF};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h20,  32'h00001234, 4, 1'b0, 1'b0, 32'h0,        1, 8,  32'hDE5A1234};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 32'h21,  32'h0000FFFF, 1, 1'b1, 1'b0, 32'h0,        0, 8,  32'hDE5A1234};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 32'h20,  32'hFFFFFFFF, 1, 1'b1, 1'b0, 32'h0,        0, 8,  32'hDE5A1234};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'h22,  32'h11111111, 1, 1'b1, 1'b0, 32'h0,        0, 8,  32'hDE5A1234};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h23,  32'h000000A5, 4, 1'b0, 1'b0, 32'h0,        1, 8,  32'hA55A1234};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'h22,  32'hCAFEBEEF, 4, 1'b0, 1'b0, 32'h0,        1, 8,  32'hBEEF1234};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h420, 32'h0,        2, 1'b0, 1'b1, 32'hBEEF1234, 0, 8,  32'hBEEF1234};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h21,  32'h0,        2, 1'b0, 1'b1, 32'hBEEF1234, 0, 8,  32'hBEEF1234};
    vecs[12] = '{1'b0, 1'b0, 2'b01, 32'h23,  32'h0,        1, 1'b1, 1'b0, 32'h0,        0, 8,  32'hBEEF1234};
    vecs[13] = '{1'b0, 1'b1, 2'b00, 32'h501, 32'h000000C3, 4, 1'b0, 1'b0, 32'h0,        1, 64, 32'h0000C300};

    preload(8'd5, 32'h00500093);
    preload(8'd8, 32'h0);
    preload(8'd64, 32'h0);

    @(negedge clk);
    checkOutput("reset_i_ack", {31'b0, i_ack}, 32'h0);
    checkOutput("reset_d_ack", {31'b0, d_ack}, 32'h0);
    checkOutput("reset_d_err", {31'b0, d_err}, 32'h0);
    checkOutput("reset_ram_wren", {31'b0, ram_wren}, 32'h0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset_ram_data", ram_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 14; i++) runVector(i, vecs[i]);

    $display("[TB] arbitration with both requesters saturating");
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h20; d_wdata = '0;
    seq = '0; k = 0; ncyc = 0; both = 1'b0;
    while (k < 10 && ncyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      if (i_ack && d_ack) both = 1'b1;
      if (i_ack) begin
        seq[k] = 1'b1;
        k++;
      end else if (d_ack) begin
        seq[k] = 1'b0;
        k++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("arb_ack_count", 32'(k), 32'd10);
    checkOutput("arb_grant_order", {22'b0, seq}, {22'b0, 10'b1000010000});
    checkOutput("arb_both_acks", {31'b0, both}, 32'h0);

    $display("[TB] reset during RMW merge");
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h22; d_wdata = 32'h00000077;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("rst_mrg_i_ack", {31'b0, i_ack}, 32'h0);
    checkOutput("rst_mrg_d_ack", {31'b0, d_ack}, 32'h0);
    checkOutput("rst_mrg_wren", {31'b0, ram_wren}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mrg_no_late_ack", {31'b0, d_ack}, 32'h0);
    checkOutput("rst_mrg_mem_word", mem[8], 32'hBEEF1234);

    $display("[TB] reset during RMW write");
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h22; d_wdata = 32'h00000077;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rmw_wr_wren_high", {31'b0, ram_wren}, 32'h1);
    checkOutput("rmw_wr_merged_data", ram_data, 32'hBE771234);
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("rst_wr_wren", {31'b0, ram_wren}, 32'h0);
    checkOutput("rst_wr_ram_data", ram_data, 32'h0);
    checkOutput("rst_wr_d_ack", {31'b0, d_ack}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_mem_word", mem[8], 32'hBEEF1234);

    fv = vecs[0];
    runVector(100, fv);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
